// File: rtl/tile_dealer.sv
// Board generator: deals NUM_TILES colour pairs (fill, then Fisher-Yates shuffle driven by a free-running LFSR),
// serves registered 11-bit tile codes by index and tracks matched pairs until the whole board is matched.
module tile_dealer #(
  parameter int          NUM_TILES = 10,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        deal,
  input  logic [3:0]  rd_index,
  input  logic        match_we,
  input  logic [3:0]  match_a,
  input  logic [3:0]  match_b,
  output logic [10:0] rd_tile,
  output logic        busy,
  output logic        done,
  output logic        tile_valid,
  output logic        all_matched
);

  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [3:0]  LAST_IDX  = 4'(NUM_TILES - 1);
  localparam logic [15:0] TILE_MASK = 16'((32'd1 << NUM_TILES) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_SHUFFLE,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  idx;
  logic [3:0]  idx_nxt;
  logic        accept;

  logic [15:0] lfsr;
  logic [5:0]  colour [16];
  logic [15:0] flipped;

  logic [11:0] prod;
  logic [3:0]  swap_j;
  logic        wr_ok;
  logic        a_ok;
  logic        b_ok;

  // j = floor(r * (i+1) / 256) with r in 0..255, so j never exceeds i
  assign prod   = {4'b0, lfsr[7:0]} * {7'b0, ({1'b0, idx} + 5'd1)};
  assign swap_j = 4'(prod >> 8);

  // A deal accepted in the same cycle drops the match write
  assign wr_ok = match_we && tile_valid && (state == S_IDLE) && !accept;
  assign a_ok  = int'(match_a) < NUM_TILES;
  assign b_ok  = int'(match_b) < NUM_TILES;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (deal) begin
          accept    = 1'b1;
          state_nxt = S_FILL;
          idx_nxt   = 4'd0;
        end
      end
      S_FILL: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_SHUFFLE;
          idx_nxt   = LAST_IDX;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
      S_SHUFFLE: begin
        if (idx <= 4'd1) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt = idx - 4'd1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tile_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      busy  <= (state_nxt == S_FILL) || (state_nxt == S_SHUFFLE);
      done  <= (state == S_DONE);
      if (accept) begin
        tile_valid <= 1'b0;
      end else if (state == S_DONE) begin
        tile_valid <= 1'b1;
      end
    end
  end

  // Free-running in every state so the press time seeds the shuffle
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_INIT;
    end else if (lfsr[0]) begin
      lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr <= lfsr >> 1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        colour[k] <= 6'd0;
      end
      flipped <= 16'd0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (k < NUM_TILES) begin
          if (state == S_FILL && idx == 4'(k)) begin
            colour[k]  <= 6'((k >> 1) + 1);
            flipped[k] <= 1'b0;
          end else if (state == S_SHUFFLE && idx == 4'(k)) begin
            colour[k] <= colour[swap_j];
          end else if (state == S_SHUFFLE && swap_j == 4'(k)) begin
            colour[k] <= colour[idx];
          end else if (wr_ok && ((a_ok && match_a == 4'(k)) || (b_ok && match_b == 4'(k)))) begin
            flipped[k] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      all_matched <= 1'b0;
    end else if (accept) begin
      all_matched <= 1'b0;
    end else begin
      all_matched <= tile_valid && ((flipped & TILE_MASK) == TILE_MASK);
    end
  end

  // Row/col come straight from the index; reads see flip state before any same-cycle write
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rd_tile <= 11'd0;
    end else if (tile_valid && int'(rd_index) < NUM_TILES) begin
      rd_tile <= {rd_index, colour[rd_index], flipped[rd_index]};
    end else begin
      rd_tile <= 11'd0;
    end
  end

endmodule
